// File: rtl/pushbutton_irq_servicer.sv
// Avalon-MM master for the pushbutton PIO: programs irq_mask, services edge-capture
// interrupts and queues one event per captured button for a valid/ready consumer.
module pushbutton_irq_servicer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [3:0]  MASK_INIT = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cfg_mask,
    input  logic        cfg_load,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    input  logic        pio_irq,
    output logic        evt_valid,
    output logic [1:0]  evt_button,
    input  logic        evt_ready,
    output logic [7:0]  overflow_count,
    output logic        busy
);

    localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
    localparam logic [1:0]      AddrMask = 2'd2;
    localparam logic [1:0]      AddrCap  = 2'd3;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRead,
        StLatch,
        StClear,
        StEmit
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      pending_q, pending_d, pending_rest;
    logic [1:0]      emit_idx;
    logic [3:0]      cfg_q;
    logic            load_pend_q;
    logic            mask_issue;
    logic            cs_d, wn_d;
    logic [1:0]      addr_d;
    logic [31:0]     wd_d;

    logic [1:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push, pop, full, push_ok;

    // Only the four capture bits carry information.
    logic unused_rdata;
    assign unused_rdata = ^pio_readdata[31:4];

    // Lowest set pending bit wins; the loop runs high-to-low so the last hit is the lowest.
    always_comb begin
        emit_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) emit_idx = 2'(i);
        end
    end

    assign pending_rest = pending_q & ~(4'b0001 << emit_idx);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        cs_d       = 1'b0;
        wn_d       = 1'b1;
        addr_d     = 2'd0;
        wd_d       = 32'd0;
        mask_issue = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            StInit: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = AddrMask;
                wd_d    = {28'd0, MASK_INIT};
                state_d = StIdle;
            end
            StIdle: begin
                if (load_pend_q) begin
                    cs_d       = 1'b1;
                    wn_d       = 1'b0;
                    addr_d     = AddrMask;
                    wd_d       = {28'd0, cfg_q};
                    mask_issue = 1'b1;
                end else if (pio_irq) begin
                    cs_d    = 1'b1;
                    addr_d  = AddrCap;
                    state_d = StRead;
                end
            end
            StRead: state_d = StLatch;
            StLatch: begin
                pending_d = pio_readdata[3:0];
                cs_d      = 1'b1;
                wn_d      = 1'b0;
                addr_d    = AddrCap;
                state_d   = StClear;
            end
            StClear: state_d = StEmit;
            StEmit: begin
                if (pending_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    push      = 1'b1;
                    pending_d = pending_rest;
                    if (pending_rest == 4'd0) state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StInit;
            pending_q      <= 4'd0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= 2'd0;
            pio_writedata  <= 32'd0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            pio_chipselect <= cs_d;
            pio_write_n    <= wn_d;
            pio_address    <= addr_d;
            pio_writedata  <= wd_d;
        end
    end

    // A new request in the same cycle the old one is issued keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q       <= 4'd0;
            load_pend_q <= 1'b0;
        end else if (cfg_load) begin
            cfg_q       <= cfg_mask;
            load_pend_q <= 1'b1;
        end else if (mask_issue) begin
            load_pend_q <= 1'b0;
        end
    end

    assign evt_valid  = (count_q != '0);
    assign evt_button = evt_valid ? mem_q[rd_ptr_q] : 2'd0;
    assign pop        = evt_valid && evt_ready;
    assign full       = (count_q == FullCnt);
    assign push_ok    = push && (!full || pop);
    assign busy       = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= emit_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_count <= 8'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (push && !push_ok && overflow_count != 8'hFF) begin
                overflow_count <= overflow_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pushbutton_irq_servicer.sv
// Bench for pushbutton_irq_servicer: behavioural PIO model on the bus side and an
// event-queue reference model on the consumer side.
module tb_pushbutton_irq_servicer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cfg_mask = 4'd0;
    logic        cfg_load = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        pio_irq;
    logic        evt_valid;
    logic [1:0]  evt_button;
    logic        evt_ready = 1'b0;
    logic [7:0]  overflow_count;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];
    int ovf_m  = 0;

    always #5 clk = ~clk;

    pushbutton_irq_servicer #(.DEPTH(DEPTH), .MASK_INIT(4'hF)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_mask       (cfg_mask),
        .cfg_load       (cfg_load),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_valid      (evt_valid),
        .evt_button     (evt_button),
        .evt_ready      (evt_ready),
        .overflow_count (overflow_count),
        .busy           (busy)
    );

    // PIO model: not reset by the servicer's reset, so capture bits survive it.
    logic [3:0]  cap      = 4'd0;
    logic [3:0]  pmask    = 4'd0;
    logic [3:0]  btn_edge = 4'd0;
    logic [31:0] rdata    = 32'd0;
    logic [31:0] last_wr2 = 32'd0;
    int          wr2_cnt  = 0;

    always @(posedge clk) begin
        if (pio_chipselect && pio_write_n && pio_address == 2'd3) rdata <= {28'd0, cap};
        else if (pio_chipselect && pio_write_n && pio_address == 2'd2) rdata <= {28'd0, pmask};
        else rdata <= 32'd0;
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2) begin
            pmask    <= pio_writedata[3:0];
            last_wr2 <= pio_writedata;
            wr2_cnt  <= wr2_cnt + 1;
        end
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3) cap <= btn_edge;
        else cap <= cap | btn_edge;
    end

    assign pio_readdata = rdata;
    assign pio_irq      = |(cap & pmask);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge after the edge where IDLE samples pio_irq.
    task automatic press(input logic [3:0] b);
        btn_edge = b;
        @(negedge clk);
        btn_edge = 4'd0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("svc_timeout", 32'(busy), 32'd0);
    endtask

    // Reference: captured buttons become events in ascending index order, dropped when full.
    task automatic model_service(input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                if (exp_q.size() < int'(DEPTH)) exp_q.push_back(i);
                else if (ovf_m < 255) ovf_m++;
            end
        end
    endtask

    task automatic drain();
        int   g;
        logic r;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            r = 1'($urandom_range(0, 1));
            chk("drain_valid", 32'(evt_valid), 32'd1);
            if (r) begin
                chk("drain_order", 32'(evt_button), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            evt_ready = r;
            @(negedge clk);
            g++;
        end
        evt_ready = 1'b0;
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        chk("drain_empty", 32'(evt_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles, first_k, last_k, w0, bad_wr;
        int obs[$];
        logic [3:0] bits;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_button", 32'(evt_button), 32'd0);
        chk("rst_ovf", 32'(overflow_count), 32'd0);
        chk("rst_cs", 32'(pio_chipselect), 32'd0);
        chk("rst_wn", 32'(pio_write_n), 32'd1);
        chk("rst_addr", 32'(pio_address), 32'd0);
        chk("rst_wd", pio_writedata, 32'd0);

        // Mask write right after release, then idle bus.
        reset = 1'b0;
        @(negedge clk);
        chk("init_cs", 32'(pio_chipselect), 32'd1);
        chk("init_wn", 32'(pio_write_n), 32'd0);
        chk("init_addr", 32'(pio_address), 32'd2);
        chk("init_wd", pio_writedata, 32'h0000000F);
        chk("init_to_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("init_bus_idle", 32'(pio_chipselect), 32'd0);
        chk("init_wr_count", 32'(wr2_cnt), 32'd1);
        chk("init_pmask", 32'(pmask), 32'hF);
        chk("init_valid", 32'(evt_valid), 32'd0);

        // Button 2: cycle-exact service.
        press(4'b0100);
        chk("b2_read_cs", 32'(pio_chipselect), 32'd1);
        chk("b2_read_wn", 32'(pio_write_n), 32'd1);
        chk("b2_read_addr", 32'(pio_address), 32'd3);
        chk("b2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2_latch_idle_bus", 32'(pio_chipselect), 32'd0);
        @(negedge clk);
        chk("b2_clr_cs", 32'(pio_chipselect), 32'd1);
        chk("b2_clr_wn", 32'(pio_write_n), 32'd0);
        chk("b2_clr_addr", 32'(pio_address), 32'd3);
        chk("b2_clr_wd", pio_writedata, 32'd0);
        chk("b2_irq_still_high", 32'(pio_irq), 32'd1);
        @(negedge clk);
        chk("b2_irq_low_e3", 32'(pio_irq), 32'd0);
        chk("b2_no_evt_e3", 32'(evt_valid), 32'd0);
        chk("b2_busy_emit", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2_evt_valid", 32'(evt_valid), 32'd1);
        chk("b2_evt_button", 32'(evt_button), 32'd2);
        chk("b2_done", 32'(busy), 32'd0);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk("b2_popped", 32'(evt_valid), 32'd0);

        // Buttons 0,1,3 in one capture, consumer always ready.
        evt_ready = 1'b1;
        press(4'b1011);
        busy_cycles = 0;
        first_k = -1;
        last_k = -1;
        obs.delete();
        for (int k = 0; k < 10; k++) begin
            if (busy) busy_cycles++;
            if (evt_valid) begin
                obs.push_back(int'(evt_button));
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        chk("multi_busy_cycles", 32'(busy_cycles), 32'd6);
        chk("multi_evt_count", 32'(obs.size()), 32'd3);
        chk("multi_consecutive", 32'(last_k - first_k), 32'd2);
        if (obs.size() == 3) begin
            chk("multi_evt0", 32'(obs[0]), 32'd0);
            chk("multi_evt1", 32'(obs[1]), 32'd1);
            chk("multi_evt2", 32'(obs[2]), 32'd3);
        end

        // Ten random single-button events into a stalled consumer.
        exp_q.delete();
        ovf_m = 0;
        for (int n = 0; n < 10; n++) begin
            bits = 4'b0001 << $urandom_range(0, 3);
            press(bits);
            wait_idle();
            model_service(bits);
        end
        chk("ovf_count", 32'(overflow_count), 32'(ovf_m));
        chk("ovf_is_two", 32'(ovf_m), 32'd2);
        drain();

        // Random multi-button captures, stalled consumer, then randomly paced drain.
        for (int n = 0; n < 5; n++) begin
            bits = 4'($urandom_range(1, 15));
            press(bits);
            wait_idle();
            model_service(bits);
        end
        chk("rand_ovf_count", 32'(overflow_count), 32'(ovf_m));
        drain();

        // Mask load during EMIT is deferred until IDLE.
        evt_ready = 1'b1;
        w0 = wr2_cnt;
        press(4'b1111);
        repeat (3) @(negedge clk);
        chk("cfg_in_emit", 32'(busy), 32'd1);
        cfg_mask = 4'h5;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        bad_wr = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy && pio_chipselect && !pio_write_n && pio_address == 2'd2) bad_wr++;
            @(negedge clk);
        end
        evt_ready = 1'b0;
        chk("cfg_no_busy_write", 32'(bad_wr), 32'd0);
        chk("cfg_one_write", 32'(wr2_cnt - w0), 32'd1);
        chk("cfg_wr_data", last_wr2, 32'h00000005);
        chk("cfg_pmask", 32'(pmask), 32'h5);
        chk("cfg_drained", 32'(evt_valid), 32'd0);
        cfg_mask = 4'hF;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("cfg_restore", 32'(pmask), 32'hF);

        // Reset during CLEAR with three queued events.
        exp_q.delete();
        for (int n = 0; n < 3; n++) begin
            bits = 4'b0001 << $urandom_range(0, 3);
            press(bits);
            wait_idle();
            model_service(bits);
        end
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        press(4'b0100);
        repeat (2) @(negedge clk);
        chk("pre_rst_clear_addr", 32'(pio_address), 32'd3);
        chk("pre_rst_clear_wn", 32'(pio_write_n), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_ovf", 32'(overflow_count), 32'd0);
        chk("mid_rst_cs", 32'(pio_chipselect), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rerst_init_addr", 32'(pio_address), 32'd2);
        chk("rerst_init_wn", 32'(pio_write_n), 32'd0);
        chk("rerst_init_wd", pio_writedata, 32'h0000000F);
        chk("rerst_cap_kept", 32'(cap), 32'h4);
        @(negedge clk);
        chk("rerst_service", 32'(busy), 32'd1);
        wait_idle();
        model_service(4'b0100);
        chk("rerst_ovf", 32'(overflow_count), 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
